// File: rtl/sequential_divider_if.sv
// Start/operand/result bundle shared by the sequential divider and its requester.
interface sequential_divider_if #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
);
  logic               start;
  logic [N_WIDTH-1:0] dividend;
  logic [D_WIDTH-1:0] divisor;
  logic [N_WIDTH-1:0] quotient;
  logic [D_WIDTH-1:0] remainder;
  logic               done;
  logic               busy;
  logic               div_by_zero;
  logic [2:0]         state_out;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero, state_out
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero, state_out
  );
endinterface

// File: rtl/sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/done/state_out control
// contract matching the sequential multiplier.
module sequential_divider #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_a_n,
  sequential_divider_if.slave  bus
);
  localparam int               CNT_W     = $clog2(N_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CALC      = 3'b001,
    CALC_DONE = 3'b100,
    ERR       = 3'b101
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [D_WIDTH-1:0] r_p;
  logic [N_WIDTH-1:0] r_q;
  logic [D_WIDTH-1:0] r_divisor;
  logic [N_WIDTH-1:0] r_quotient;
  logic [D_WIDTH-1:0] r_remainder;
  logic               r_div_by_zero;

  logic               w_accept;
  logic               w_zero_div;
  logic               w_step;
  logic               w_last;
  logic               w_ge;
  logic [D_WIDTH:0]   w_p_sh;
  logic [D_WIDTH-1:0] w_sub;
  logic [D_WIDTH-1:0] w_p_next;
  logic [N_WIDTH-1:0] w_q_next;

  assign w_accept   = ((r_state == IDLE) || (r_state == ERR)) && bus.start;
  assign w_zero_div = (bus.divisor == {D_WIDTH{1'b0}});
  assign w_step     = (r_state == CALC) && !bus.start;
  assign w_last     = w_step && (r_count == LAST_STEP);

  // P stays below the divisor, so the shifted value fits D_WIDTH+1 bits and the
  // trial difference never needs more than D_WIDTH bits when it is kept.
  assign w_p_sh   = {r_p, r_q[N_WIDTH-1]};
  assign w_ge     = (w_p_sh >= {1'b0, r_divisor});
  assign w_sub    = D_WIDTH'(w_p_sh - {1'b0, r_divisor});
  assign w_p_next = w_ge ? w_sub : w_p_sh[D_WIDTH-1:0];
  assign w_q_next = {r_q[N_WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Any unreachable encoding falls into ERR so a new start can recover it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, ERR: begin
        if (bus.start) begin
          w_next_state = w_zero_div ? ERR : CALC;
        end else begin
          w_next_state = r_state;
        end
      end
      CALC: begin
        if (bus.start) begin
          w_next_state = ERR;
        end else if (r_count == LAST_STEP) begin
          w_next_state = CALC_DONE;
        end else begin
          w_next_state = CALC;
        end
      end
      CALC_DONE: begin
        w_next_state = bus.start ? ERR : IDLE;
      end
      default: begin
        w_next_state = ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      r_count       <= {CNT_W{1'b0}};
      r_p           <= {D_WIDTH{1'b0}};
      r_q           <= {N_WIDTH{1'b0}};
      r_divisor     <= {D_WIDTH{1'b0}};
      r_quotient    <= {N_WIDTH{1'b0}};
      r_remainder   <= {D_WIDTH{1'b0}};
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_div_by_zero <= 1'b1;
      end else begin
        r_count       <= {CNT_W{1'b0}};
        r_p           <= {D_WIDTH{1'b0}};
        r_q           <= bus.dividend;
        r_divisor     <= bus.divisor;
        r_div_by_zero <= 1'b0;
      end
    end else if (w_step) begin
      r_p     <= w_p_next;
      r_q     <= w_q_next;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_p_next;
      end
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.done        = (r_state == CALC_DONE);
  assign bus.busy        = (r_state == CALC);
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.state_out   = r_state;
endmodule
